// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter that responds on the NBBPU data bus.
// The CPU queues bytes in a small TX FIFO and polls STATUS; the bit period comes from DIVISOR.
module uart_tx_port #(
    parameter logic [15:0] BASE_ADDRESS    = 16'hFF00,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        select,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic [15:0] address,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        tx
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [15:0]     timer_q, timer_d;
    logic [15:0]     bp_q, bp_d;
    logic            tx_q, tx_d;
    logic [7:0]      fifo_q [FIFO_DEPTH];
    logic [7:0]      fifo_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     divisor_q, divisor_d;
    logic [15:0]     read_data_q, read_data_d;

    logic            hit, wr_hit, rd_hit;
    logic [1:0]      offset;
    logic            full, empty, busy;
    logic            pop, push_req, push, drop;
    logic [15:0]     bp_next;
    logic [15:0]     status;

    // Bus decode, FIFO bookkeeping, transmitter FSM and register read mux.
    always_comb begin
        hit      = select && (address[15:2] == BASE_ADDRESS[15:2]);
        wr_hit   = hit && write_enable;
        rd_hit   = hit && read_enable;
        offset   = address[1:0];
        full     = (count_q == CW'(FIFO_DEPTH));
        empty    = (count_q == {CW{1'b0}});
        busy     = (state_q != ST_IDLE) || !empty;
        bp_next  = (divisor_q == 16'd0) ? 16'd1 : divisor_q;

        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        timer_d   = timer_q;
        bp_d      = bp_q;
        pop       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pop = !empty;
            end
            ST_START: begin
                if (timer_q == 16'd0) begin
                    state_d   = ST_DATA;
                    timer_d   = bp_q - 16'd1;
                    bit_idx_d = 3'd0;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (timer_q == 16'd0) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    timer_d = bp_q - 16'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (timer_q == 16'd0) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A pop always starts a fresh frame; the bit period is latched here so DIVISOR writes wait.
        if (pop) begin
            state_d   = ST_START;
            shift_d   = fifo_q[rd_ptr_q];
            bp_d      = bp_next;
            timer_d   = bp_next - 16'd1;
            bit_idx_d = 3'd0;
        end else begin
            bp_d = bp_q;
        end

        case (state_q)
            ST_IDLE:  tx_d = 1'b1;
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_q[0];
            ST_STOP:  tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase

        push_req = wr_hit && (offset == 2'd0);
        push     = push_req && (!full || pop);
        drop     = push_req && !push;

        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q] = write_data[7:0];
        end else begin
            fifo_d = fifo_q;
        end
        wr_ptr_d = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
        end else if (wr_hit && (offset == 2'd1) && write_data[3]) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        divisor_d = (wr_hit && (offset == 2'd2)) ? write_data : divisor_q;

        status = {7'd0, 5'(count_q), overflow_q, empty, full, busy};

        if (rd_hit) begin
            case (offset)
                2'd1:    read_data_d = status;
                2'd2:    read_data_d = divisor_q;
                default: read_data_d = 16'd0;
            endcase
        end else begin
            read_data_d = 16'd0;
        end
    end

    // State registers; reset overrides any bus access in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= 8'd0;
            bit_idx_q   <= 3'd0;
            timer_q     <= 16'd0;
            bp_q        <= 16'd0;
            tx_q        <= 1'b1;
            fifo_q      <= '{default: 8'd0};
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
            overflow_q  <= 1'b0;
            divisor_q   <= DEFAULT_DIVISOR;
            read_data_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            timer_q     <= timer_d;
            bp_q        <= bp_d;
            tx_q        <= tx_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            divisor_q   <= divisor_d;
            read_data_q <= read_data_d;
        end
    end

    assign read_data = read_data_q;
    assign tx        = tx_q;

endmodule

// File: doc/uart_tx_port.md
Name: uart_tx_port

Overview:
- Memory-mapped UART transmitter that acts as a responder on the NBBPU data bus, sitting beside the data RAM and sharing `select`, `read_enable`, `write_enable`, `address`, `write_data` and `read_data`.
- The CPU writes bytes into a small TX FIFO, then polls status.
- The block serialises bytes as 8N1 frames on `tx` at a programmable bit period.
- `read_data` is zero when the block is not addressed, so the SoC top ORs it with the RAM `read_data`.

Parameters:
- BASE_ADDRESS, 16'hFF00: word address of register 0. Bits [1:0] must be 0.
- FIFO_DEPTH, 4: TX FIFO entries. Must be a power of 2, from 2 to 16.
- DEFAULT_DIVISOR, 16'd434: reset value of the DIVISOR register, in clocks per bit.

Ports:
- clock, input, 1: system clock. The block has one clock only.
- reset, input, 1: synchronous, active-high reset.
- select, input, 1: bus select. No access occurs unless it is high.
- read_enable, input, 1: read strobe.
- write_enable, input, 1: write strobe.
- address, input, 16: word address.
- write_data, input, 16: write data.
- read_data, output, 16: registered read data. It is 0 when the block is not addressed.
- tx, output, 1: serial output, registered. Idle level is high.

Behaviour:
- Hit decode: `hit` = `select` and `address[15:2] == BASE_ADDRESS[15:2]`. The register offset is `address[1:0]`.
- Register map:
  - Offset 0, DATA. A write pushes `write_data[7:0]` into the FIFO. A read returns 0.
  - Offset 1, STATUS (read):
    - bit0: busy (FSM not in IDLE, or FIFO not empty).
    - bit1: full.
    - bit2: empty.
    - bit3: overflow, sticky.
    - bits[8:4]: FIFO count.
    - All other bits read 0.
  - Offset 1, STATUS (write): writing with bit3 = 1 clears overflow. All other bits are ignored.
  - Offset 2, DIVISOR. Read and write, 16 bits. Writing 0 stores 0, and the FSM treats it as 1.
  - Offset 3: reserved. Reads return 0 and writes are ignored.
- Write timing: a write takes effect at the rising edge where `write_enable` and `hit` are both high.
- Read timing: at an edge where `read_enable` and `hit` are high, `read_data` <= the selected register. At every other edge, `read_data` <= 0.
  - Read latency is 1 cycle, matching the RAM.
  - STATUS reads return the pre-edge value.
- Simultaneous read and write in the same cycle: the read returns the pre-write value.
- Push rules:
  - A push is accepted when the FIFO is not full, or when the FSM pops in the same cycle.
  - Otherwise the byte is dropped and overflow <= 1.
  - If a STATUS clear and a new overflow occur in the same cycle, the set wins.
- FIFO:
  - Circular buffer with read and write pointers of log2(FIFO_DEPTH) bits, which wrap naturally.
  - A separate count runs from 0 to FIFO_DEPTH.
  - Count is unchanged on a simultaneous push and pop.
- FSM state IDLE:
  - `tx` = 1.
  - If the FIFO is not empty: pop the head into shift[7:0], latch the bit period `bp` = max(DIVISOR, 1), clear the bit counter, and go to START.
  - If the FIFO is empty, stay in IDLE.
- FSM state START: `tx` = 0 for `bp` clocks, then go to DATA.
- FSM state DATA:
  - `tx` = shift[0] for `bp` clocks per bit.
  - After each bit, shift right and increment the bit index.
  - After 8 bits, go to STOP. Bits are sent LSB first.
- FSM state STOP:
  - `tx` = 1 for `bp` clocks.
  - At the end, if the FIFO is not empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Frame length is exactly 10 × `bp` clocks.
- Start latency: a DATA write at edge N with the FSM in IDLE gives a pop at edge N+1, and `tx` falls at edge N+2. `tx` is registered from state and shift.
- DIVISOR writes during a frame do not alter the current frame. The new value applies from the next pop.
- Bit timer: a 16-bit down-counter loaded with `bp` − 1. The state or bit advances when it reaches 0.
- Reset values:
  - `tx` = 1, `read_data` = 0.
  - State IDLE, FIFO empty (pointers and count 0).
  - overflow = 0, DIVISOR = DEFAULT_DIVISOR.
  - Shift register and counters = 0.
- Reset mid-frame: the frame is aborted, `tx` is 1 after the next edge, and the FIFO is flushed.
- Reset has priority over any bus access in the same cycle.

Test Plan:
- Reset, then read STATUS and DIVISOR → STATUS = 16'h0004 (empty) and DIVISOR = 434; `tx` = 1. A read at address 16'h0100 → `read_data` = 0.
- Write DIVISOR = 4, then DATA = 16'h1255 → `tx` sequence at 4 clocks per bit is 0,1,0,1,0,1,0,1,0,1 (start, 0x55 LSB first, stop), lasting 40 clocks. Bits [15:8] are ignored. STATUS ends at 16'h0004.
- DIVISOR = 1, then 3 back-to-back DATA writes (0xA0, 0x0F, 0xFF) → three frames with no idle cycle between stop and start. STATUS shows busy with a decreasing count; the last frame ends at clock 30 after the first `tx` fall.
- DIVISOR = 100, then 6 fast DATA writes (0x01–0x06) with FIFO_DEPTH = 4 → the first byte is popped and 4 are queued. The 6th write is dropped: STATUS bit3 = 1 and bit1 = 1, and 0x06 is never transmitted. Writing STATUS = 16'h0008 → bit3 = 0.
- DIVISOR = 0, then DATA = 16'h0080 → bit period of 1 clock, `tx` = 0,0,0,0,0,0,0,0,1,1.
- DIVISOR = 8 and start frame 0x3C. Assert reset for 1 cycle mid-DATA → `tx` = 1 after the next edge, STATUS = 16'h0004, DIVISOR = 434, and no further frames are sent.
